// File: rtl/if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register
//
// Pipeline register between instruction fetch (IF) and instruction decode
// (ID). It also detects load-use hazards.
//
// Every cycle it captures the fetched instruction, the PC and PC+4, and it
// tracks whether the stage holds a real instruction. A taken branch or jump
// (Flush) replaces the fetched instruction with a NOP and marks it invalid.
// When the load in EX writes a register that the held instruction reads,
// the stage holds its contents for one cycle. During that cycle it freezes
// the fetch PC and tells decode to insert a bubble. Two saturating counters
// record stall cycles and flush cycles for debug.
//
// Ports
//   Clock            in   1   system clock, rising-edge active
//   Reset            in   1   asynchronous, active-high; clears all state
//   Instruction_In   in  32   instruction from instruction memory
//   PCAdder_In       in  32   PC+4 from the fetch adder
//   PCResult_In      in  32   current PC from fetch
//   Flush            in   1   taken branch/jump: squash the fetched instruction
//   ID_EX_MemRead    in   1   instruction in EX is a load
//   ID_EX_Rt         in   5   destination register of that load
//   Instruction_Out  out 32   registered instruction to decode
//   PCAdder_Out      out 32   registered PC+4
//   PCResult_Out     out 32   registered PC
//   Valid_Out        out  1   stage holds a real instruction
//   PCWrite          out  1   fetch PC enable (combinational)
//   Bubble           out  1   decode control-mux select (combinational)
//   StallCount       out 16   hazard cycles, saturating at 0xFFFF
//   FlushCount       out 16   flush cycles, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module if_id_register (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instruction_In,
    input  logic [31:0] PCAdder_In,
    input  logic [31:0] PCResult_In,
    input  logic        Flush,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_Rt,
    output logic [31:0] Instruction_Out,
    output logic [31:0] PCAdder_Out,
    output logic [31:0] PCResult_Out,
    output logic        Valid_Out,
    output logic        PCWrite,
    output logic        Bubble,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [4:0] rs_field;
    logic [4:0] rt_field;
    logic       field_match;
    logic       hazard;

    assign rs_field = Instruction_Out[25:21];
    assign rt_field = Instruction_Out[20:16];

    // Both source fields are compared whatever the instruction format.
    // An instruction that does not read rt can therefore stall
    // needlessly. That costs one cycle and never gives a wrong result.
    assign field_match = (ID_EX_Rt == rs_field) || (ID_EX_Rt == rt_field);

    always_comb begin
        // NOTE: give every always_comb target a default first, so that no
        // path leaves it unassigned and a latch is never inferred.
        hazard = 1'b0;
        // A flush discards the held instruction, so stalling for it would
        // only delay the branch target.
        if (!Flush && Valid_Out && ID_EX_MemRead &&
            (ID_EX_Rt != 5'd0) && field_match) begin
            hazard = 1'b1;
        end
    end

    assign PCWrite = ~hazard;
    assign Bubble  = hazard;

    // Pipeline contents: flush beats hazard, and hazard beats a normal load.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples its pre-edge value regardless of block order.
            Instruction_Out <= NOP;
            PCAdder_Out     <= 32'h0000_0000;
            PCResult_Out    <= 32'h0000_0000;
            Valid_Out       <= 1'b0;
        end else if (Flush) begin
            Instruction_Out <= NOP;
            PCAdder_Out     <= PCAdder_In;
            PCResult_Out    <= PCResult_In;
            Valid_Out       <= 1'b0;
        end else if (!hazard) begin
            Instruction_Out <= Instruction_In;
            PCAdder_Out     <= PCAdder_In;
            PCResult_Out    <= PCResult_In;
            Valid_Out       <= 1'b1;
        end
    end

    // Debug counters: they stop at all-ones, so a long run never wraps
    // back to a small, misleading value.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            StallCount <= 16'h0000;
            FlushCount <= 16'h0000;
        end else begin
            if (hazard && (StallCount != CNT_MAX)) begin
                StallCount <= StallCount + 16'h0001;
            end
            if (Flush && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + 16'h0001;
            end
        end
    end

endmodule
